// File: rtl/yutorina_ex_stage.sv
// Yutorina execute stage: the ALU, an iterative restoring divider, and the EX/MEM pipeline
// registers, plus a combinational forwarding path back to decode.
module yutorina_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    output logic        busy,
    input  logic        id_en_,
    input  logic [29:0] id_pc,
    input  logic [3:0]  id_alu_op,
    input  logic [31:0] id_alu_in_0,
    input  logic [31:0] id_alu_in_1,
    input  logic [31:0] id_w_data,
    input  logic [4:0]  id_w_addr,
    input  logic        id_gpr_we_,
    input  logic [1:0]  id_mem_op,
    input  logic [1:0]  id_ctrl_op,
    input  logic [2:0]  id_exp_code,
    output logic        ex_en_,
    output logic [29:0] ex_pc,
    output logic [4:0]  ex_w_addr,
    output logic [31:0] ex_w_data,
    output logic        ex_gpr_we_,
    output logic [2:0]  ex_exp_code,
    output logic [1:0]  ex_mem_op,
    output logic [1:0]  ex_ctrl_op,
    output logic [31:0] ex_out,
    output logic [4:0]  fwd_addr,
    output logic [31:0] fwd_out
);

    localparam logic       ENABLE_  = 1'b0;
    localparam logic       DISABLE_ = 1'b1;
    localparam logic [4:0] GPR_ZERO = 5'd0;

    localparam logic [2:0] EXP_NONE     = 3'd0;
    localparam logic [2:0] EXP_OVERFLOW = 3'd3;
    localparam logic [1:0] MEM_NONE     = 2'd0;
    localparam logic [1:0] CTRL_NONE    = 2'd0;

    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_ADDU = 4'd2;
    localparam logic [3:0] ALU_SUB  = 4'd3;
    localparam logic [3:0] ALU_SUBU = 4'd4;
    localparam logic [3:0] ALU_AND  = 4'd5;
    localparam logic [3:0] ALU_OR   = 4'd6;
    localparam logic [3:0] ALU_XOR  = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_MUL  = 4'd11;
    localparam logic [3:0] ALU_DIV  = 4'd12;
    localparam logic [3:0] ALU_DIVU = 4'd13;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [31:0] sum;
    logic [31:0] diff;
    logic [31:0] mul_lo;
    logic [31:0] alu_out;
    logic        ovf;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] dsr;
    logic        neg;

    logic        is_div;
    logic        start;
    logic        dvd_neg;
    logic        dsr_neg;
    logic [31:0] dvd_abs;
    logic [31:0] dsr_abs;
    logic [32:0] partial;
    logic [32:0] trial;
    logic [31:0] div_result;
    logic [31:0] result;

    assign sum    = id_alu_in_0 + id_alu_in_1;
    assign diff   = id_alu_in_0 - id_alu_in_1;
    assign mul_lo = id_alu_in_0 * id_alu_in_1;

    always_comb begin
        alu_out = 32'd0;
        ovf     = 1'b0;
        case (id_alu_op)
            ALU_ADD: begin
                alu_out = sum;
                ovf     = (id_alu_in_0[31] == id_alu_in_1[31]) && (sum[31] != id_alu_in_0[31]);
            end
            ALU_ADDU: alu_out = sum;
            ALU_SUB: begin
                alu_out = diff;
                ovf     = (id_alu_in_0[31] != id_alu_in_1[31]) && (diff[31] != id_alu_in_0[31]);
            end
            ALU_SUBU: alu_out = diff;
            ALU_AND:  alu_out = id_alu_in_0 & id_alu_in_1;
            ALU_OR:   alu_out = id_alu_in_0 | id_alu_in_1;
            ALU_XOR:  alu_out = id_alu_in_0 ^ id_alu_in_1;
            ALU_SLL:  alu_out = id_alu_in_0 << id_alu_in_1[4:0];
            ALU_SRL:  alu_out = id_alu_in_0 >> id_alu_in_1[4:0];
            ALU_SRA:  alu_out = $signed(id_alu_in_0) >>> id_alu_in_1[4:0];
            ALU_MUL:  alu_out = mul_lo;
            default:  alu_out = 32'd0;
        endcase
    end

    // Divider operands are taken as magnitudes; the sign is restored on the way out.
    assign is_div  = (id_alu_op == ALU_DIV) || (id_alu_op == ALU_DIVU);
    assign start   = (state == ST_IDLE) && (id_en_ == ENABLE_) && is_div && !flush;
    assign busy    = start || (state == ST_RUN);
    assign dvd_neg = (id_alu_op == ALU_DIV) && id_alu_in_0[31];
    assign dsr_neg = (id_alu_op == ALU_DIV) && id_alu_in_1[31];
    assign dvd_abs = dvd_neg ? (32'd0 - id_alu_in_0) : id_alu_in_0;
    assign dsr_abs = dsr_neg ? (32'd0 - id_alu_in_1) : id_alu_in_1;

    // A set bit 32 of the trial difference means the subtraction went negative.
    assign partial = {rem, quo[31]};
    assign trial   = partial - {1'b0, dsr};

    assign div_result = neg ? (32'd0 - quo) : quo;
    assign result     = (state == ST_DONE) ? div_result : alu_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 5'd0;
            quo   <= 32'd0;
            rem   <= 32'd0;
            dsr   <= 32'd0;
            neg   <= 1'b0;
        end else if (flush) begin
            state <= ST_IDLE;
            cnt   <= 5'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        quo   <= dvd_abs;
                        dsr   <= dsr_abs;
                        rem   <= 32'd0;
                        neg   <= dvd_neg ^ dsr_neg;
                        cnt   <= 5'd0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    rem <= trial[32] ? partial[31:0] : trial[31:0];
                    quo <= {quo[30:0], ~trial[32]};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!stall) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign fwd_out  = result;
    assign fwd_addr = ((id_en_ == ENABLE_) && (id_gpr_we_ == ENABLE_) && !ovf) ? id_w_addr
                                                                               : GPR_ZERO;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_en_      <= DISABLE_;
            ex_pc       <= 30'd0;
            ex_w_addr   <= GPR_ZERO;
            ex_gpr_we_  <= DISABLE_;
            ex_exp_code <= EXP_NONE;
            ex_mem_op   <= MEM_NONE;
            ex_ctrl_op  <= CTRL_NONE;
            ex_w_data   <= 32'd0;
            ex_out      <= 32'd0;
        end else if (stall) begin
            ex_en_      <= ex_en_;
        end else if (flush) begin
            ex_en_      <= DISABLE_;
            ex_pc       <= id_pc;
            ex_w_addr   <= GPR_ZERO;
            ex_gpr_we_  <= DISABLE_;
            ex_exp_code <= EXP_NONE;
            ex_mem_op   <= MEM_NONE;
            ex_ctrl_op  <= CTRL_NONE;
            ex_w_data   <= 32'd0;
            ex_out      <= 32'd0;
        end else if (ovf && (id_en_ == ENABLE_) && (id_exp_code == EXP_NONE)) begin
            // An upstream exception outranks overflow, so this only fires on a clean instruction.
            ex_en_      <= id_en_;
            ex_pc       <= id_pc;
            ex_w_addr   <= GPR_ZERO;
            ex_gpr_we_  <= DISABLE_;
            ex_exp_code <= EXP_OVERFLOW;
            ex_mem_op   <= MEM_NONE;
            ex_ctrl_op  <= CTRL_NONE;
            ex_w_data   <= 32'd0;
            ex_out      <= 32'd0;
        end else begin
            ex_en_      <= id_en_;
            ex_pc       <= id_pc;
            ex_w_addr   <= id_w_addr;
            ex_gpr_we_  <= id_gpr_we_;
            ex_exp_code <= id_exp_code;
            ex_mem_op   <= id_mem_op;
            ex_ctrl_op  <= id_ctrl_op;
            ex_w_data   <= id_w_data;
            ex_out      <= result;
        end
    end

endmodule
